// File: rtl/time_manager.sv
// Emulated-time step sequencer.
// Finds the earliest enabled client time and issues one step per pass.
module time_manager #(
  parameter int N_CLIENTS   = 2,
  parameter int TIME_WIDTH  = 32,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            run,
  input  logic [N_CLIENTS-1:0]            client_en,
  input  logic [N_CLIENTS*TIME_WIDTH-1:0] time_in,
  input  logic [TIME_WIDTH-1:0]           time_limit,
  output logic [TIME_WIDTH-1:0]           time_next,
  output logic [TIME_WIDTH-1:0]           emu_time,
  output logic [COUNT_WIDTH-1:0]          step_count,
  output logic                            step,
  output logic                            done,
  output logic                            stalled
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COMPUTE,
    S_STEP,
    S_DONE
  } state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic [TIME_WIDTH-1:0]  r_min;
  logic [TIME_WIDTH-1:0]  r_emu;
  logic [COUNT_WIDTH-1:0] r_cnt;
  logic [TIME_WIDTH-1:0]  w_min;
  logic                   w_any;

  // Unsigned minimum over the enabled clients only.
  always_comb begin
    w_min = '1;
    w_any = 1'b0;
    for (int i = 0; i < N_CLIENTS; i++) begin
      if (client_en[i]) begin
        w_any = 1'b1;
        if (time_in[i*TIME_WIDTH +: TIME_WIDTH] < w_min)
          w_min = time_in[i*TIME_WIDTH +: TIME_WIDTH];
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Capture the minimum while computing; commit time and count on a step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_min <= '0;
      r_emu <= '0;
      r_cnt <= '0;
    end else begin
      if (r_state == S_COMPUTE && w_any)
        r_min <= w_min;
      if (r_state == S_STEP) begin
        r_emu <= r_min;
        r_cnt <= r_cnt + COUNT_WIDTH'(1);
      end
    end
  end

  // Next state and outputs; time_next/step come from registered state only.
  always_comb begin
    w_next    = r_state;
    time_next = '1;
    step      = 1'b0;
    done      = 1'b0;
    stalled   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (run) w_next = S_COMPUTE;
      end
      S_COMPUTE: begin
        stalled = ~w_any;
        if (!run)                    w_next = S_IDLE;
        else if (!w_any)             w_next = S_COMPUTE;
        else if (w_min >= time_limit) w_next = S_DONE;
        else                         w_next = S_STEP;
      end
      S_STEP: begin
        time_next = r_min;
        step      = 1'b1;
        w_next    = S_COMPUTE;
      end
      S_DONE: begin
        done = 1'b1;
        if (!run) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign emu_time   = r_emu;
  assign step_count = r_cnt;

endmodule
